// File: rtl/iir_coef_loader.sv
// iir_coef_loader
//
// Writer side of the IIR cascade coefficient storage. A framed word stream
// (valid/ready) fills a shadow bank holding the input scale, one scale per
// SOS and b0,b1,b2,a1,a2 per SOS. Once the frame checksum matches, the whole
// shadow bank is copied to the active bank in a single CE-enabled cycle, so
// the filter never observes a partially written coefficient set.
//
// Frame: MAGIC, NUMBER+1 scale words, NUMBER*5 coef words, checksum word.
// Checksum is the modulo-2^W sum of MAGIC and every scale and coef word.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   CE         filter clock enable; commit only happens on a CE=1 cycle
//   abort      drops the frame in progress (ignored while idle)
//   s_data     stream word
//   s_valid    stream word valid
//   s_ready    loader can accept a word
//   scale_flat active scales, scale k at [k*W +: W], k=0 is the input scale
//   coef_flat  active coefs, SOS k coef j (b0,b1,b2,a1,a2) at [(k*5+j)*W +: W]
//   busy       frame in progress
//   load_done  one-cycle pulse on commit
//   load_err   one-cycle pulse on a rejected frame
//   err_code   last error cause: 0 none, 1 bad header, 2 checksum, 3 abort
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for MAGIC; any other word is rejected as bad header
// SCALE  | collecting the NUMBER+1 scale words into the shadow bank
// COEF   | collecting the NUMBER*5 coef words into the shadow bank
// CHECK  | next word is the checksum, compared against the running sum
// COMMIT | checksum good, waiting for CE=1 to copy shadow to active

module iir_coef_loader #(
    parameter int                 WIS    = 5,
    parameter int                 WFS    = 11,
    parameter int                 NUMBER = 4,
    parameter logic [WIS+WFS-1:0] MAGIC  = 16'hC0EF
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              CE,
    input  logic                              abort,
    input  logic [WIS+WFS-1:0]                s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [(NUMBER+1)*(WIS+WFS)-1:0]   scale_flat,
    output logic [NUMBER*5*(WIS+WFS)-1:0]     coef_flat,
    output logic                              busy,
    output logic                              load_done,
    output logic                              load_err,
    output logic [1:0]                        err_code
);

    localparam int W     = WIS + WFS;
    localparam int NCOEF = NUMBER * 5;
    localparam int CW    = $clog2(NCOEF);
    localparam int SW    = $clog2(NUMBER + 1);

    localparam logic [CW-1:0] SCALE_LAST = CW'(NUMBER);
    localparam logic [CW-1:0] COEF_LAST  = CW'(NCOEF - 1);

    localparam logic [W-1:0] ONE = W'(1) << WFS;

    // Pass-through power-up bank: unity scales, b0 = 1.0, everything else 0.
    function automatic logic [NCOEF*W-1:0] coef_rst_value();
        logic [NCOEF*W-1:0] v;
        v = '0;
        for (int k = 0; k < NUMBER; k++) begin
            v[k*5*W +: W] = ONE;
        end
        return v;
    endfunction

    localparam logic [(NUMBER+1)*W-1:0] SCALE_RST = {(NUMBER+1){ONE}};
    localparam logic [NCOEF*W-1:0]      COEF_RST  = coef_rst_value();

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCALE  = 3'd1,
        ST_COEF   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [CW-1:0]              r_cnt;
    logic [W-1:0]               r_sum;
    logic [NUMBER:0][W-1:0]     r_scale_sh;
    logic [NCOEF-1:0][W-1:0]    r_coef_sh;
    logic [NUMBER:0][W-1:0]     r_scale_act;
    logic [NCOEF-1:0][W-1:0]    r_coef_act;
    logic                       r_load_done;
    logic                       r_load_err;
    logic [1:0]                 r_err_code;

    logic       w_ready;
    logic       w_xfer;
    logic       w_hdr_ok;
    logic       w_scale_wr;
    logic       w_coef_wr;
    logic       w_commit;
    logic       w_err;
    logic [1:0] w_err_code;

    // Ready is held low while reset is applied and while a commit is pending.
    assign w_ready = !RST && (r_state != ST_COMMIT);
    assign w_xfer  = s_valid && w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hdr_ok   = 1'b0;
        w_scale_wr = 1'b0;
        w_coef_wr  = 1'b0;
        w_commit   = 1'b0;
        w_err      = 1'b0;
        w_err_code = r_err_code;
        // Abort outranks both a word transfer and a CE commit in the same cycle.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nx = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (s_data == MAGIC) begin
                            w_hdr_ok   = 1'b1;
                            w_state_nx = ST_SCALE;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = 2'd1;
                        end
                    end
                end
                ST_SCALE: begin
                    if (w_xfer) begin
                        w_scale_wr = 1'b1;
                        if (r_cnt == SCALE_LAST) begin
                            w_state_nx = ST_COEF;
                        end
                    end
                end
                ST_COEF: begin
                    if (w_xfer) begin
                        w_coef_wr = 1'b1;
                        if (r_cnt == COEF_LAST) begin
                            w_state_nx = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        if (s_data == r_sum) begin
                            w_state_nx = ST_COMMIT;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = 2'd2;
                            w_state_nx = ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (CE) begin
                        w_commit   = 1'b1;
                        w_err_code = 2'd0;
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= '0;
            r_sum       <= '0;
            r_scale_sh  <= '0;
            r_coef_sh   <= '0;
            r_scale_act <= SCALE_RST;
            r_coef_act  <= COEF_RST;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_load_done <= w_commit;
            r_load_err  <= w_err;
            r_err_code  <= w_err_code;
            if (w_hdr_ok) begin
                r_sum <= MAGIC;
                r_cnt <= '0;
            end
            if (w_scale_wr) begin
                r_scale_sh[r_cnt[SW-1:0]] <= s_data;
                r_sum <= r_sum + s_data;
                r_cnt <= (r_cnt == SCALE_LAST) ? '0 : r_cnt + CW'(1);
            end
            if (w_coef_wr) begin
                r_coef_sh[r_cnt] <= s_data;
                r_sum <= r_sum + s_data;
                r_cnt <= (r_cnt == COEF_LAST) ? '0 : r_cnt + CW'(1);
            end
            if (w_commit) begin
                r_scale_act <= r_scale_sh;
                r_coef_act  <= r_coef_sh;
            end
        end
    end

    assign s_ready    = w_ready;
    assign busy       = (r_state != ST_IDLE);
    assign scale_flat = r_scale_act;
    assign coef_flat  = r_coef_act;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_iir_coef_loader.sv
// Testbench for iir_coef_loader: random frames checked against a
// transaction-level model of the active coefficient bank.

module tb_iir_coef_loader;

    localparam int          W     = 16;
    localparam int          N     = 4;
    localparam int          NC    = N * 5;
    localparam int          FLEN  = 1 + (N + 1) + NC + 1;
    localparam logic [15:0] MAGIC = 16'hC0EF;
    localparam logic [15:0] ONE   = 16'h0800;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  CE = 1'b1;
    logic                  abort = 1'b0;
    logic [W-1:0]          s_data = '0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [(N+1)*W-1:0]    scale_flat;
    logic [NC*W-1:0]       coef_flat;
    logic                  busy;
    logic                  load_done;
    logic                  load_err;
    logic [1:0]            err_code;

    iir_coef_loader #(
        .WIS    (5),
        .WFS    (11),
        .NUMBER (N),
        .MAGIC  (MAGIC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .abort      (abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .scale_flat (scale_flat),
        .coef_flat  (coef_flat),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_scale [N+1];
    logic [15:0] m_coef  [NC];
    logic [15:0] f_scale [N+1];
    logic [15:0] f_coef  [NC];
    logic [15:0] fq [$];
    bit          g_gaps = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] exp_scale();
        logic [511:0] v;
        v = '0;
        for (int k = 0; k <= N; k++) v[k*W +: W] = m_scale[k];
        return v;
    endfunction

    function automatic logic [511:0] exp_coef();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i*W +: W] = m_coef[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k <= N; k++) m_scale[k] = ONE;
        for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? ONE : 16'h0000;
    endfunction

    function automatic void model_commit();
        for (int k = 0; k <= N; k++) m_scale[k] = f_scale[k];
        for (int i = 0; i < NC; i++) m_coef[i] = f_coef[i];
    endfunction

    function automatic void rand_frame();
        for (int k = 0; k <= N; k++) f_scale[k] = 16'($urandom);
        for (int i = 0; i < NC; i++) f_coef[i] = 16'($urandom);
    endfunction

    function automatic void build_frame(input logic [15:0] cs_delta);
        int sum;
        fq.delete();
        fq.push_back(MAGIC);
        sum = int'(MAGIC);
        for (int k = 0; k <= N; k++) begin
            fq.push_back(f_scale[k]);
            sum += int'(f_scale[k]);
        end
        for (int i = 0; i < NC; i++) begin
            fq.push_back(f_coef[i]);
            sum += int'(f_coef[i]);
        end
        fq.push_back(16'((sum + int'(cs_delta)) % 65536));
    endfunction

    // Starts and ends just after a falling edge; the word is taken on the
    // rising edge in between.
    task automatic send_word(input logic [15:0] d);
        int guard;
        if (g_gaps) begin
            int n;
            n = $urandom_range(0, 3);
            repeat (n) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                @(negedge CLK);
            end
        end
        s_data  = d;
        s_valid = 1'b1;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!s_ready) chk("s_ready_wait", s_ready, 1);
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_word(fq[i]);
    endtask

    task automatic check_bank(input string tag);
        chk({tag, "_scale"}, scale_flat, exp_scale());
        chk({tag, "_coef"}, coef_flat, exp_coef());
    endtask

    // Called right after the checksum word has been taken with CE=1.
    task automatic expect_commit(input string tag);
        chk({tag, "_pend_busy"}, busy, 1);
        chk({tag, "_pend_ready"}, s_ready, 0);
        chk({tag, "_pend_done"}, load_done, 0);
        @(negedge CLK);
        model_commit();
        chk({tag, "_done"}, load_done, 1);
        chk({tag, "_noerr"}, load_err, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_busy"}, busy, 0);
        check_bank(tag);
        @(negedge CLK);
        chk({tag, "_done_off"}, load_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_ready", s_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_code", err_code, 0);
        chk("idle_done", load_done, 0);
        chk("idle_err", load_err, 0);
        check_bank("rst");

        // Fixed frame, checksum off by one: rejected, bank untouched.
        for (int k = 0; k <= N; k++) f_scale[k] = 16'h0400;
        for (int i = 0; i < NC; i++) f_coef[i] = 16'(i + 1);
        build_frame(16'd1);
        send_range(0, FLEN);
        chk("cs_err", load_err, 1);
        chk("cs_code", err_code, 2);
        chk("cs_busy", busy, 0);
        chk("cs_done", load_done, 0);
        check_bank("cs");
        @(negedge CLK);
        chk("cs_err_off", load_err, 0);
        chk("cs_code_hold", err_code, 2);

        // Same frame, good checksum.
        build_frame(16'd0);
        send_range(0, FLEN);
        expect_commit("fixed");

        // Bad header, then a valid frame back to back.
        send_word(16'h1234);
        chk("hdr_err", load_err, 1);
        chk("hdr_code", err_code, 1);
        chk("hdr_busy", busy, 0);
        rand_frame();
        build_frame(16'd0);
        send_range(0, FLEN);
        expect_commit("after_hdr");

        // CE held low for 10 cycles after the checksum.
        rand_frame();
        build_frame(16'd0);
        send_range(0, FLEN - 1);
        CE = 1'b0;
        send_word(fq[FLEN-1]);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("ce_wait_ready", s_ready, 0);
            chk("ce_wait_done", load_done, 0);
            chk("ce_wait_scale", scale_flat, exp_scale());
        end
        check_bank("ce_wait");
        CE = 1'b1;
        expect_commit("ce_late");

        // Abort after the 7th word.
        rand_frame();
        build_frame(16'd0);
        send_range(0, 7);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("ab7_err", load_err, 1);
        chk("ab7_code", err_code, 3);
        chk("ab7_busy", busy, 0);
        chk("ab7_done", load_done, 0);
        check_bank("ab7");

        // Abort on the same cycle as a CE=1 commit.
        rand_frame();
        build_frame(16'd0);
        send_range(0, FLEN);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abc_err", load_err, 1);
        chk("abc_done", load_done, 0);
        chk("abc_code", err_code, 3);
        chk("abc_busy", busy, 0);
        check_bank("abc");
        @(negedge CLK);
        chk("abc_done_late", load_done, 0);

        // Abort while idle is ignored, even alongside the header word.
        abort = 1'b1;
        rand_frame();
        build_frame(16'd0);
        send_word(fq[0]);
        abort = 1'b0;
        chk("idle_abort_err", load_err, 0);
        chk("idle_abort_busy", busy, 1);
        send_range(1, FLEN);
        expect_commit("idle_abort");

        // Random s_valid gaps mid-frame.
        g_gaps = 1;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            build_frame(16'd0);
            send_range(0, FLEN);
            expect_commit("gaps");
        end
        g_gaps = 0;

        // Reset in the middle of a frame restores the pass-through bank.
        rand_frame();
        build_frame(16'd0);
        send_range(0, 10);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_ready", s_ready, 0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check_bank("mrst");
        chk("mrst_busy", busy, 0);
        chk("mrst_ready_after", s_ready, 1);
        chk("mrst_code", err_code, 0);

        rand_frame();
        build_frame(16'd0);
        send_range(0, FLEN);
        expect_commit("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iir_coef_loader.md
Name: iir_coef_loader

Overview:
- Writer side of the IIR cascade's coefficient storage.
- Accepts a framed stream of fixed-point words over a valid/ready handshake and fills a shadow bank: one input scale, one scale per SOS, and b0,b1,b2,a1,a2 per SOS.
- Verifies a checksum, then commits the whole shadow bank to the active bank in one cycle, aligned to a CE-enabled cycle. The filter therefore never sees a partial coefficient set.
- Sits between the host/config interface and the IIR, which reads the flat active-bank outputs.

Parameters:
- WIS, 5, integer bits of each coefficient/scale word
- WFS, 11, fractional bits of each coefficient/scale word
- NUMBER, 4, number of SOS stages in the cascade
- MAGIC, 16'hC0EF, frame header value (width WIS+WFS)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- CE  in  1  active-high clock enable of the filter; commit occurs only on a cycle with CE=1
- abort  in  1  synchronous abort of the frame in progress
- s_data  in  W=WIS+WFS  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- scale_flat  out  (NUMBER+1)*W  active scales; index k occupies [k*W +: W], k=0 is the input scale
- coef_flat  out  NUMBER*5*W  active coefficients; SOS k, coef j (0=b0,1=b1,2=b2,3=a1,4=a2) occupies [(k*5+j)*W +: W]
- busy  out  1  frame in progress (state not IDLE)
- load_done  out  1  one-cycle pulse on commit
- load_err  out  1  one-cycle pulse on rejected frame
- err_code  out  2  holds cause of last error: 0 none, 1 bad header, 2 checksum mismatch, 3 abort

Behaviour:
- Word transfer occurs only when s_valid=1 and s_ready=1 on a rising CLK edge.
- Frame format: MAGIC, NUMBER+1 scale words (k=0..NUMBER), NUMBER*5 coef words (SOS 0 first, b0..a2 order), checksum word. Default frame is 27 words.
- Checksum = sum mod 2^W of MAGIC plus all scale and coef words.
- State machine:
  - IDLE: s_ready=1. Word==MAGIC → SCALE, running sum=MAGIC, counter=0. Any other word is discarded: pulse load_err, err_code=1, stay IDLE.
  - SCALE: s_ready=1. Each word is written to shadow scale[cnt] and added to the sum. After the word with cnt=NUMBER → COEF, counter=0.
  - COEF: s_ready=1. Each word is written to shadow coef[cnt] and added to the sum. After cnt=NUMBER*5-1 → CHECK.
  - CHECK: s_ready=1.
    - Word==sum → COMMIT.
    - Else pulse load_err, err_code=2, → IDLE. Active bank is untouched.
  - COMMIT: s_ready=0. On the first cycle with CE=1: copy shadow→active (all fields in the same edge), pulse load_done, err_code=0, → IDLE. With CE=0, wait indefinitely.
- s_valid=0 mid-frame stalls without limit; no timeout.
- Reset:
  - State IDLE, counter 0, sum 0, shadow bank 0.
  - Active scale[k]=1.0 (value 1<<WFS) for all k.
  - Active coef: b0=1.0 per SOS, all others 0, so the cascade powers up as pass-through.
  - s_ready=0 during reset, 1 the cycle after; busy=0, load_done=0, load_err=0, err_code=0.
- abort=1 in any non-IDLE state → IDLE next cycle, pulse load_err, err_code=3. Shadow contents are don't-care; active bank is unchanged.
  - abort in IDLE is ignored.
  - abort takes priority over a simultaneous transfer and over a simultaneous CE commit. An aborted COMMIT does not update the active bank.
- RST has priority over abort and everything else. Reset mid-frame restores the pass-through active bank.
- Sum width is W and wraps modulo 2^W.
- Counters are sized for NUMBER*5-1 and never wrap within a frame.
- Outputs scale_flat and coef_flat are registered and change only on commit or reset.
- load_done and load_err never assert in the same cycle.

Test Plan:
- Reset then idle → scale_flat words all 16'h0800, coef_flat b0 words 16'h0800 and others 0, s_ready=1, busy=0.
- Full 27-word frame with scales 16'h0400, coefs (k*5+j+1), correct checksum, CE=1 → load_done pulse 1 cycle after the checksum accept. Active bank matches. err_code=0.
- Same frame with checksum+1 → load_err pulse, err_code=2, active bank still reset values.
- Header 16'h1234 → load_err, err_code=1, busy stays 0. A valid frame following immediately is accepted and committed.
- Valid frame with CE held 0 for 10 cycles after checksum → s_ready=0 and no update during the wait. Commit on the first CE=1 cycle.
- abort asserted after the 7th word, and separately on a cycle with CE=1 while in COMMIT → load_err, err_code=3, no active update. s_valid toggling randomly mid-frame still yields a correct commit.
